// File: rtl/canxl_aes_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : canxl_aes_arbiter_if
// Brief    : Requester, engine and status bundle for the CAN-XL AES arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface canxl_aes_arbiter_if #(
  parameter int DATA_W = 128
);
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              tx_gnt;
  logic              tx_done;
  logic [DATA_W-1:0] tx_result;

  logic              rx_req;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] rx_icv;
  logic              rx_gnt;
  logic              rx_done;
  logic [DATA_W-1:0] rx_result;
  logic              rx_icv_ok;

  logic              abort;
  logic              aes_enable;
  logic [DATA_W-1:0] aes_datain;
  logic [DATA_W-1:0] aes_dataout;
  logic              aes_done;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  tx_req, tx_data, rx_req, rx_data, rx_icv, abort, aes_dataout, aes_done,
    output tx_gnt, tx_done, tx_result, rx_gnt, rx_done, rx_result, rx_icv_ok,
           aes_enable, aes_datain, busy, timeout_err
  );

  modport master (
    output tx_req, tx_data, rx_req, rx_data, rx_icv, abort, aes_dataout, aes_done,
    input  tx_gnt, tx_done, tx_result, rx_gnt, rx_done, rx_result, rx_icv_ok,
           aes_enable, aes_datain, busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/canxl_aes_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : canxl_aes_arbiter
// Brief    : Round-robin share of one AES-128 engine between CAN-SEC TX ICV
//            generation and RX ICV verification, with watchdog and abort.
// Revision : 1.0 - initial release
// ============================================================================
module canxl_aes_arbiter #(
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                  clk,
  input  logic                  g_rst_n,
  canxl_aes_arbiter_if.slave    bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;
  localparam logic [1:0] c_GAP  = 2'd3;

  localparam logic c_OWN_TX = 1'b0;
  localparam logic c_OWN_RX = 1'b1;

  localparam logic [CNT_W-1:0] c_WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  wd_q, wd_d;
  logic [DATA_W-1:0] icv_q, icv_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] datain_q, datain_d;
  logic              tx_gnt_q, tx_gnt_d;
  logic              rx_gnt_q, rx_gnt_d;
  logic              tx_done_q, tx_done_d;
  logic              rx_done_q, rx_done_d;
  logic [DATA_W-1:0] tx_res_q, tx_res_d;
  logic [DATA_W-1:0] rx_res_q, rx_res_d;
  logic              ok_q, ok_d;
  logic              to_q, to_d;
  logic              w_pick_rx;

  // RX wins when alone, or on contention when TX was served last.
  assign w_pick_rx = bus.rx_req & (~bus.tx_req | (last_q == c_OWN_TX));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wd_d      = wd_q;
    icv_d     = icv_q;
    en_d      = en_q;
    datain_d  = datain_q;
    tx_gnt_d  = 1'b0;
    rx_gnt_d  = 1'b0;
    tx_done_d = 1'b0;
    rx_done_d = 1'b0;
    tx_res_d  = tx_res_q;
    rx_res_d  = rx_res_q;
    ok_d      = ok_q;
    to_d      = 1'b0;

    case (state_q)
      c_IDLE: begin
        if (bus.tx_req || bus.rx_req) begin
          owner_d = w_pick_rx;
          en_d    = 1'b1;
          wd_d    = '0;
          state_d = c_RUN;
          if (w_pick_rx) begin
            datain_d = bus.rx_data;
            icv_d    = bus.rx_icv;
            rx_gnt_d = 1'b1;
          end else begin
            datain_d = bus.tx_data;
            tx_gnt_d = 1'b1;
          end
        end
      end
      c_RUN: begin
        wd_d = wd_q + 1'b1;
        if (bus.abort) begin
          en_d    = 1'b0;
          state_d = c_GAP;
        end else if (bus.aes_done) begin
          en_d    = 1'b0;
          state_d = c_RESP;
          if (owner_q == c_OWN_RX) begin
            rx_res_d  = bus.aes_dataout;
            ok_d      = (bus.aes_dataout == icv_q);
            rx_done_d = 1'b1;
          end else begin
            tx_res_d  = bus.aes_dataout;
            tx_done_d = 1'b1;
          end
        end else if (wd_q == c_WD_LAST) begin
          // Engine hung: hand the owner a zero result so it is not left waiting.
          en_d    = 1'b0;
          to_d    = 1'b1;
          state_d = c_RESP;
          if (owner_q == c_OWN_RX) begin
            rx_res_d  = '0;
            ok_d      = 1'b0;
            rx_done_d = 1'b1;
          end else begin
            tx_res_d  = '0;
            tx_done_d = 1'b1;
          end
        end
      end
      c_RESP: begin
        last_d  = owner_q;
        state_d = c_GAP;
      end
      c_GAP: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      state_q   <= c_IDLE;
      owner_q   <= c_OWN_TX;
      last_q    <= c_OWN_TX;
      wd_q      <= '0;
      icv_q     <= '0;
      en_q      <= 1'b0;
      datain_q  <= '0;
      tx_gnt_q  <= 1'b0;
      rx_gnt_q  <= 1'b0;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      tx_res_q  <= '0;
      rx_res_q  <= '0;
      ok_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      icv_q     <= icv_d;
      en_q      <= en_d;
      datain_q  <= datain_d;
      tx_gnt_q  <= tx_gnt_d;
      rx_gnt_q  <= rx_gnt_d;
      tx_done_q <= tx_done_d;
      rx_done_q <= rx_done_d;
      tx_res_q  <= tx_res_d;
      rx_res_q  <= rx_res_d;
      ok_q      <= ok_d;
      to_q      <= to_d;
    end
  end

  assign bus.tx_gnt      = tx_gnt_q;
  assign bus.tx_done     = tx_done_q;
  assign bus.tx_result   = tx_res_q;
  assign bus.rx_gnt      = rx_gnt_q;
  assign bus.rx_done     = rx_done_q;
  assign bus.rx_result   = rx_res_q;
  assign bus.rx_icv_ok   = ok_q;
  assign bus.aes_enable  = en_q;
  assign bus.aes_datain  = datain_q;
  assign bus.busy        = (state_q != c_IDLE);
  assign bus.timeout_err = to_q;

endmodule
`default_nettype wire
